// File: rtl/mips_exec_core.sv
// mips_exec_core: decode/execute/writeback of a two-stage MIPS subset core (control unit, 32x32 GPR file, ALU with HI/LO).
// Latency: EX result registered into the *_wb outputs at the edge ending EX; GPR commit one edge later, hidden by bypass.
// Backpressure: none; one instruction is consumed every cycle and dependent instructions never stall.
// Ports: clk/rst (async, active-high); instr_ex = instruction in EX; gpio_in sampled by the GPIO-read instruction;
//   gpio_out registered GPIO output; rs_data/rt_data bypassed register reads; alu_lo/alu_zero combinational ALU result;
//   regwrite_wb/writeaddr_wb/writedata_wb registered writeback that also drives the register-file write port.
module mips_exec_core #(
  parameter int NREGS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_ex,
  input  logic [31:0] gpio_in,
  output logic [31:0] gpio_out,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic [31:0] alu_lo,
  output logic        alu_zero,
  output logic        regwrite_wb,
  output logic [4:0]  writeaddr_wb,
  output logic [31:0] writedata_wb
);

  typedef enum logic [3:0] {
    ALU_AND   = 4'd0,
    ALU_OR    = 4'd1,
    ALU_XOR   = 4'd2,
    ALU_NOR   = 4'd3,
    ALU_ADD   = 4'd4,
    ALU_SUB   = 4'd5,
    ALU_MULT  = 4'd6,
    ALU_MULTU = 4'd7,
    ALU_SLL   = 4'd8,
    ALU_SRL   = 4'd9,
    ALU_SRA   = 4'd10,
    ALU_SLT   = 4'd12,
    ALU_SLTU  = 4'd13
  } alu_op_t;

  typedef enum logic [1:0] {
    SRC_RT   = 2'd0,
    SRC_SEXT = 2'd1,
    SRC_ZEXT = 2'd2
  } alu_src_t;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_HI   = 2'd1,
    WB_LO   = 2'd2,
    WB_GPIO = 2'd3
  } wb_sel_t;

  // instruction fields
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [4:0]  rd_addr;
  logic [4:0]  shamt_f;
  logic [15:0] imm;

  assign opcode  = instr_ex[31:26];
  assign rs_addr = instr_ex[25:21];
  assign rt_addr = instr_ex[20:16];
  assign rd_addr = instr_ex[15:11];
  assign shamt_f = instr_ex[10:6];
  assign funct   = instr_ex[5:0];
  assign imm     = instr_ex[15:0];

  // control
  alu_op_t    alu_op;
  alu_src_t   alu_src;
  wb_sel_t    regsel;
  logic       reg_write;
  logic [4:0] dest;
  logic       lui_shift;
  logic       hilo_we;
  logic       gpio_we;

  // state
  logic [31:0] gpr [NREGS];
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  // datapath
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_hi;
  logic [4:0]  shamt;
  logic        mul_signed;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] product;
  logic [31:0] wb_data;

  always_comb begin
    alu_op    = ALU_AND;
    alu_src   = SRC_RT;
    regsel    = WB_ALU;
    reg_write = 1'b0;
    dest      = 5'd0;
    lui_shift = 1'b0;
    hilo_we   = 1'b0;
    gpio_we   = 1'b0;
    case (opcode)
      6'h00: begin
        dest = rd_addr;
        case (funct)
          6'h00:        begin alu_op = ALU_SLL;  reg_write = 1'b1; end
          6'h02:        begin alu_op = ALU_SRL;  reg_write = 1'b1; end
          6'h03:        begin alu_op = ALU_SRA;  reg_write = 1'b1; end
          6'h20, 6'h21: begin alu_op = ALU_ADD;  reg_write = 1'b1; end
          6'h22, 6'h23: begin alu_op = ALU_SUB;  reg_write = 1'b1; end
          6'h24:        begin alu_op = ALU_AND;  reg_write = 1'b1; end
          6'h25:        begin alu_op = ALU_OR;   reg_write = 1'b1; end
          6'h26:        begin alu_op = ALU_XOR;  reg_write = 1'b1; end
          6'h27:        begin alu_op = ALU_NOR;  reg_write = 1'b1; end
          6'h2A:        begin alu_op = ALU_SLT;  reg_write = 1'b1; end
          6'h2B:        begin alu_op = ALU_SLTU; reg_write = 1'b1; end
          6'h18:        begin alu_op = ALU_MULT;  hilo_we = 1'b1; end
          6'h19:        begin alu_op = ALU_MULTU; hilo_we = 1'b1; end
          6'h10:        begin regsel = WB_HI; reg_write = 1'b1; end
          6'h12:        begin regsel = WB_LO; reg_write = 1'b1; end
          default:      ;
        endcase
      end
      6'h08, 6'h09: begin dest = rt_addr; alu_src = SRC_SEXT; alu_op = ALU_ADD;  reg_write = 1'b1; end
      6'h0A:        begin dest = rt_addr; alu_src = SRC_SEXT; alu_op = ALU_SLT;  reg_write = 1'b1; end
      6'h0B:        begin dest = rt_addr; alu_src = SRC_SEXT; alu_op = ALU_SLTU; reg_write = 1'b1; end
      6'h0C:        begin dest = rt_addr; alu_src = SRC_ZEXT; alu_op = ALU_AND;  reg_write = 1'b1; end
      6'h0D:        begin dest = rt_addr; alu_src = SRC_ZEXT; alu_op = ALU_OR;   reg_write = 1'b1; end
      6'h0E:        begin dest = rt_addr; alu_src = SRC_ZEXT; alu_op = ALU_XOR;  reg_write = 1'b1; end
      6'h0F: begin
        dest      = rt_addr;
        alu_src   = SRC_ZEXT;
        alu_op    = ALU_SLL;
        lui_shift = 1'b1;
        reg_write = 1'b1;
      end
      6'h10: begin
        if (rs_addr == 5'h00) begin
          dest      = rt_addr;
          regsel    = WB_GPIO;
          reg_write = 1'b1;
        end else if (rs_addr == 5'h04) begin
          gpio_we = 1'b1;
        end
      end
      default: ;
    endcase
    // r0 is hardwired, so a write to it is dropped here; this also keeps NOP off the writeback path
    if (dest == 5'd0) reg_write = 1'b0;
  end

  // register reads with bypass from the pending writeback
  assign rs_data = (rs_addr == 5'd0) ? 32'd0 :
                   (regwrite_wb && writeaddr_wb == rs_addr) ? writedata_wb : gpr[rs_addr];
  assign rt_data = (rt_addr == 5'd0) ? 32'd0 :
                   (regwrite_wb && writeaddr_wb == rt_addr) ? writedata_wb : gpr[rt_addr];

  assign alu_a = rs_data;
  always_comb begin
    case (alu_src)
      SRC_SEXT: alu_b = {{16{imm[15]}}, imm};
      SRC_ZEXT: alu_b = {16'd0, imm};
      default:  alu_b = rt_data;
    endcase
  end

  assign shamt = lui_shift ? 5'd16 : shamt_f;

  // one 64-bit multiplier serves both MULT and MULTU; operands are sign- or zero-extended to 64 bits
  assign mul_signed = (alu_op == ALU_MULT);
  assign mul_a      = {{32{mul_signed & alu_a[31]}}, alu_a};
  assign mul_b      = {{32{mul_signed & alu_b[31]}}, alu_b};
  assign product    = mul_a * mul_b;

  always_comb begin
    alu_lo = 32'd0;
    alu_hi = 32'd0;
    case (alu_op)
      ALU_AND:   alu_lo = alu_a & alu_b;
      ALU_OR:    alu_lo = alu_a | alu_b;
      ALU_XOR:   alu_lo = alu_a ^ alu_b;
      ALU_NOR:   alu_lo = ~(alu_a | alu_b);
      ALU_ADD:   alu_lo = alu_a + alu_b;
      ALU_SUB:   alu_lo = alu_a - alu_b;
      ALU_MULT,
      ALU_MULTU: {alu_hi, alu_lo} = product;
      ALU_SLL:   alu_lo = alu_b << shamt;
      ALU_SRL:   alu_lo = alu_b >> shamt;
      ALU_SRA:   alu_lo = $signed(alu_b) >>> shamt;
      ALU_SLT:   alu_lo = {31'd0, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU:  alu_lo = {31'd0, alu_a < alu_b};
      default:   ;
    endcase
  end

  assign alu_zero = (alu_lo == 32'd0);

  always_comb begin
    case (regsel)
      WB_HI:   wb_data = hi_q;
      WB_LO:   wb_data = lo_q;
      WB_GPIO: wb_data = gpio_in;
      default: wb_data = alu_lo;
    endcase
  end

  // writeback, HI/LO and GPIO registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regwrite_wb  <= 1'b0;
      writeaddr_wb <= 5'd0;
      writedata_wb <= 32'd0;
      hi_q         <= 32'd0;
      lo_q         <= 32'd0;
      gpio_out     <= 32'd0;
    end else begin
      regwrite_wb  <= reg_write;
      writeaddr_wb <= dest;
      writedata_wb <= wb_data;
      if (hilo_we) begin
        hi_q <= alu_hi;
        lo_q <= alu_lo;
      end
      if (gpio_we) gpio_out <= rt_data;
    end
  end

  // register file commits the writeback one edge after EX
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) gpr[i] <= 32'd0;
    end else if (regwrite_wb && writeaddr_wb != 5'd0) begin
      gpr[writeaddr_wb] <= writedata_wb;
    end
  end

endmodule

// File: tb/tb_mips_exec_core.sv
// tb_mips_exec_core: directed and randomized instruction streams against an ISA-level reference model.
// Latency: expects writeback outputs one edge after each instruction, GPR reads always architecturally current.
// Backpressure: none; one instruction driven per cycle.
module tb_mips_exec_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_ex;
  logic [31:0] gpio_in;
  logic [31:0] gpio_out;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] alu_lo;
  logic        alu_zero;
  logic        regwrite_wb;
  logic [4:0]  writeaddr_wb;
  logic [31:0] writedata_wb;

  mips_exec_core #(.NREGS(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr_ex     (instr_ex),
    .gpio_in      (gpio_in),
    .gpio_out     (gpio_out),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .alu_lo       (alu_lo),
    .alu_zero     (alu_zero),
    .regwrite_wb  (regwrite_wb),
    .writeaddr_wb (writeaddr_wb),
    .writedata_wb (writedata_wb)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // architectural reference state
  logic [31:0] m_gpr [32];
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [31:0] m_gpio;

  typedef struct {
    logic        we;
    logic [4:0]  dst;
    logic [31:0] val;
    logic        alu_chk;
    logic [31:0] alu;
    logic        hilo_we;
    logic [63:0] prod;
    logic        gpio_we;
    logic [31:0] gval;
  } exp_t;

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [4:0] sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [15:0] im);
    return {op, rs, rt, im};
  endfunction

  // MIPS semantics of one instruction on the current architectural state
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] gin);
    exp_t e;
    logic [31:0] a, b, sx, zx;
    int ia, ib, isx;
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd, sh;
    op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; sh = ins[10:6]; fn = ins[5:0];
    a = m_gpr[rs]; b = m_gpr[rt];
    sx = {{16{ins[15]}}, ins[15:0]};
    zx = {16'd0, ins[15:0]};
    ia = a; ib = b; isx = sx;
    e.we = 1'b0; e.dst = 5'd0; e.val = 32'd0; e.alu_chk = 1'b0; e.alu = 32'd0;
    e.hilo_we = 1'b0; e.prod = 64'd0; e.gpio_we = 1'b0; e.gval = b;
    case (op)
      6'h00: begin
        e.dst = rd; e.we = 1'b1; e.alu_chk = 1'b1;
        case (fn)
          6'h00: e.alu = b << sh;
          6'h02: e.alu = b >> sh;
          6'h03: e.alu = ib >>> sh;
          6'h20, 6'h21: e.alu = a + b;
          6'h22, 6'h23: e.alu = a - b;
          6'h24: e.alu = a & b;
          6'h25: e.alu = a | b;
          6'h26: e.alu = a ^ b;
          6'h27: e.alu = ~(a | b);
          6'h2A: e.alu = (ia < ib) ? 32'd1 : 32'd0;
          6'h2B: e.alu = (a < b) ? 32'd1 : 32'd0;
          6'h18: begin e.we = 1'b0; e.hilo_we = 1'b1; e.prod = 64'(longint'(ia) * longint'(ib)); e.alu = e.prod[31:0]; end
          6'h19: begin e.we = 1'b0; e.hilo_we = 1'b1; e.prod = {32'd0, a} * {32'd0, b}; e.alu = e.prod[31:0]; end
          6'h10: begin e.alu_chk = 1'b0; e.val = m_hi; end
          6'h12: begin e.alu_chk = 1'b0; e.val = m_lo; end
          default: begin e.we = 1'b0; e.alu_chk = 1'b0; end
        endcase
        if (fn != 6'h10 && fn != 6'h12) e.val = e.alu;
      end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
        e.dst = rt; e.we = 1'b1; e.alu_chk = 1'b1;
        case (op)
          6'h08, 6'h09: e.alu = a + sx;
          6'h0A:        e.alu = (ia < isx) ? 32'd1 : 32'd0;
          6'h0B:        e.alu = (a < sx) ? 32'd1 : 32'd0;
          6'h0C:        e.alu = a & zx;
          6'h0D:        e.alu = a | zx;
          6'h0E:        e.alu = a ^ zx;
          default:      e.alu = zx << 16;
        endcase
        e.val = e.alu;
      end
      6'h10: begin
        if (rs == 5'h00) begin e.we = 1'b1; e.dst = rt; e.val = gin; end
        else if (rs == 5'h04) e.gpio_we = 1'b1;
      end
      default: ;
    endcase
    if (e.dst == 5'd0) e.we = 1'b0;
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
    m_hi = 32'd0; m_lo = 32'd0; m_gpio = 32'd0;
  endtask

  // drive one instruction for one cycle and check it end to end (entered at posedge+1)
  task automatic run(input logic [31:0] ins, input logic [31:0] gin);
    exp_t e;
    instr_ex = ins;
    gpio_in  = gin;
    #1;
    e = model(ins, gin);
    check_eq("rs_data", rs_data, m_gpr[ins[25:21]]);
    check_eq("rt_data", rt_data, m_gpr[ins[20:16]]);
    if (e.alu_chk) begin
      check_eq("alu_lo", alu_lo, e.alu);
      check_eq("alu_zero", 32'(alu_zero), (e.alu == 32'd0) ? 32'd1 : 32'd0);
    end
    @(posedge clk);
    #1;
    check_eq("regwrite_wb", 32'(regwrite_wb), 32'(e.we));
    if (e.we) begin
      check_eq("writeaddr_wb", 32'(writeaddr_wb), 32'(e.dst));
      check_eq("writedata_wb", writedata_wb, e.val);
      m_gpr[e.dst] = e.val;
    end
    if (e.hilo_we) begin
      m_hi = e.prod[63:32];
      m_lo = e.prod[31:0];
    end
    if (e.gpio_we) m_gpio = e.gval;
    check_eq("gpio_out", gpio_out, m_gpio);
  endtask

  // read a register through rs_data with an inert (unknown-opcode) instruction
  task automatic peek(input string tag, input logic [4:0] r, input logic [31:0] exp);
    instr_ex = {6'h3F, r, 21'd0};
    #1;
    check_eq(tag, rs_data, exp);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] fn_tab [17];
    logic [5:0] op_tab [8];
    logic [4:0] rs, rt, rd, sh;
    logic [15:0] im;
    int k;
    fn_tab = '{6'h00, 6'h02, 6'h03, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
               6'h26, 6'h27, 6'h2A, 6'h2B, 6'h18, 6'h19, 6'h10, 6'h12};
    op_tab = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
    rs = 5'($urandom_range(0, 7));
    rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 7));
    sh = 5'($urandom);
    im = 16'($urandom);
    k  = $urandom_range(0, 31);
    if (k < 17)       return enc_r(rs, rt, rd, sh, fn_tab[k]);
    else if (k < 25)  return enc_i(op_tab[k-17], rs, rt, im);
    else if (k == 25) return enc_i(6'h10, 5'h00, rt, im);
    else if (k == 26) return enc_i(6'h10, 5'h04, rt, im);
    else if (k == 27) return enc_i(6'h10, 5'h01, rt, im);
    else if (k == 28) return enc_i(6'h3E, rs, rt, im);
    else if (k == 29) return enc_r(rs, rt, rd, sh, 6'h01);
    else if (k == 30) return 32'd0;
    else              return enc_i(6'h08, rs, rt, im);
  endfunction

  initial begin
    logic [31:0] ins;
    model_reset();
    rst = 1'b1;
    instr_ex = 32'd0;
    gpio_in  = 32'd0;
    #12;
    check_eq("rst_regwrite", 32'(regwrite_wb), 32'd0);
    check_eq("rst_writeaddr", 32'(writeaddr_wb), 32'd0);
    check_eq("rst_writedata", writedata_wb, 32'd0);
    check_eq("rst_gpio_out", gpio_out, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // dependent addi pair through the bypass
    run(enc_i(6'h08, 5'd0, 5'd1, 16'd5), 32'd0);
    ins = enc_i(6'h08, 5'd1, 5'd2, 16'hFFFD);
    instr_ex = ins;
    #1;
    check_eq("bypass_rs", rs_data, 32'd5);
    run(ins, 32'd0);
    peek("r1_addi", 5'd1, 32'd5);
    peek("r2_addi", 5'd2, 32'd2);

    // lui/ori and zero-extended immediates
    run(enc_i(6'h0F, 5'd0, 5'd3, 16'h1234), 32'd0);
    run(enc_i(6'h0D, 5'd3, 5'd3, 16'h5678), 32'd0);
    peek("r3_lui_ori", 5'd3, 32'h12345678);
    run(enc_i(6'h0E, 5'd0, 5'd8, 16'hFFFF), 32'd0);
    run(enc_i(6'h0C, 5'd3, 5'd9, 16'hFFFF), 32'd0);
    peek("r8_xori", 5'd8, 32'h0000FFFF);
    peek("r9_andi", 5'd9, 32'h00005678);

    // signed/unsigned multiply, HI/LO read immediately after
    run(enc_i(6'h08, 5'd0, 5'd4, 16'hFFFE), 32'd0);
    run(enc_i(6'h08, 5'd0, 5'd5, 16'd3), 32'd0);
    run(enc_r(5'd4, 5'd5, 5'd0, 5'd0, 6'h18), 32'd0);
    run(enc_r(5'd0, 5'd0, 5'd10, 5'd0, 6'h10), 32'd0);
    run(enc_r(5'd0, 5'd0, 5'd11, 5'd0, 6'h12), 32'd0);
    run(enc_r(5'd4, 5'd5, 5'd0, 5'd0, 6'h19), 32'd0);
    run(enc_r(5'd0, 5'd0, 5'd12, 5'd0, 6'h10), 32'd0);
    run(enc_r(5'd0, 5'd0, 5'd13, 5'd0, 6'h12), 32'd0);
    peek("mult_hi", 5'd10, 32'hFFFFFFFF);
    peek("mult_lo", 5'd11, 32'hFFFFFFFA);
    peek("multu_hi", 5'd12, 32'h00000002);
    peek("multu_lo", 5'd13, 32'hFFFFFFFA);

    // shifts and compares
    run(enc_i(6'h0F, 5'd0, 5'd5, 16'h8000), 32'd0);
    run(enc_r(5'd0, 5'd5, 5'd6, 5'd4, 6'h03), 32'd0);
    run(enc_r(5'd0, 5'd5, 5'd14, 5'd4, 6'h02), 32'd0);
    run(enc_i(6'h08, 5'd0, 5'd16, 16'd3), 32'd0);
    run(enc_r(5'd4, 5'd16, 5'd17, 5'd0, 6'h2A), 32'd0);
    run(enc_r(5'd4, 5'd16, 5'd18, 5'd0, 6'h2B), 32'd0);
    peek("sra", 5'd6, 32'hF8000000);
    peek("srl", 5'd14, 32'h08000000);
    peek("slt", 5'd17, 32'd1);
    peek("sltu", 5'd18, 32'd0);
    ins = enc_r(5'd5, 5'd5, 5'd6, 5'd0, 6'h22);
    instr_ex = ins;
    #1;
    check_eq("sub_zero", 32'(alu_zero), 32'd1);
    run(ins, 32'd0);

    // GPIO read, write, and a write to r0
    run(enc_i(6'h10, 5'h00, 5'd7, 16'd0), 32'hA5A5A5A5);
    ins = enc_i(6'h10, 5'h04, 5'd7, 16'd0);
    instr_ex = ins;
    #1;
    check_eq("gpio_before_edge", gpio_out, 32'd0);
    run(ins, 32'd0);
    check_eq("gpio_write", gpio_out, 32'hA5A5A5A5);
    run(enc_i(6'h08, 5'd0, 5'd0, 16'd7), 32'd0);
    peek("r0_write", 5'd0, 32'd0);

    // randomized stream
    for (int i = 0; i < 400; i++) run(rand_instr(), $urandom());
    for (int r = 0; r < 32; r++) peek("gpr_final", 5'(r), m_gpr[r]);

    // reset while a writeback is pending
    run(enc_i(6'h10, 5'h04, 5'd3, 16'd0), 32'd0);
    instr_ex = enc_i(6'h08, 5'd0, 5'd20, 16'd9);
    @(posedge clk);
    #1;
    check_eq("pre_rst_regwrite", 32'(regwrite_wb), 32'd1);
    rst = 1'b1;
    instr_ex = {6'h3F, 5'd3, 21'd0};
    #1;
    check_eq("midrst_regwrite", 32'(regwrite_wb), 32'd0);
    check_eq("midrst_writeaddr", 32'(writeaddr_wb), 32'd0);
    check_eq("midrst_writedata", writedata_wb, 32'd0);
    check_eq("midrst_gpio_out", gpio_out, 32'd0);
    check_eq("midrst_r3", rs_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    peek("post_rst_r20", 5'd20, 32'd0);
    peek("post_rst_r1", 5'd1, 32'd0);
    peek("post_rst_r3", 5'd3, 32'd0);
    run(enc_r(5'd0, 5'd0, 5'd21, 5'd0, 6'h10), 32'd0);
    run(enc_r(5'd0, 5'd0, 5'd22, 5'd0, 6'h12), 32'd0);
    for (int i = 0; i < 50; i++) run(rand_instr(), $urandom());

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mips_exec_core.md
Name: mips_exec_core

Overview:
- Decode/execute/writeback datapath of a single-issue, two-stage MIPS subset CPU.
- Bundles three parts:
  - control unit: decodes the 32-bit instruction in EX;
  - 32x32 register file;
  - ALU with HI/LO registers.
- The fetch stage supplies the instruction each cycle. The block writes results back one cycle later and drives the GPIO output register.

Parameters:
- NREGS, 32, number of architectural registers (5-bit addresses).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- instr_ex  in  32  instruction in EX stage (0x00000000 = NOP).
- gpio_in  in  32  external input, sampled by the GPIO-read instruction.
- gpio_out  out  32  registered GPIO output.
- rs_data  out  32  register-file read of instr[25:21], after bypass.
- rt_data  out  32  register-file read of instr[20:16], after bypass.
- alu_lo  out  32  combinational ALU low result.
- alu_zero  out  1  1 when alu_lo == 0.
- regwrite_wb  out  1  writeback enable (registered).
- writeaddr_wb  out  5  writeback destination (registered).
- writedata_wb  out  32  writeback data (registered).

Behaviour:
- Reset: all 32 registers = 0, HI = LO = 0, gpio_out = 0, regwrite_wb = 0, writeaddr_wb = 0, writedata_wb = 0.
- Register file:
  - Two async read ports, one synchronous write port (we = regwrite_wb).
  - r0 always reads 0; writes to r0 are ignored.
  - Bypass: if regwrite_wb is set and writeaddr_wb equals a nonzero read address, that port returns writedata_wb.
- ALU (4-bit op):
  - 0 AND, 1 OR, 2 XOR, 3 NOR, 4 ADD, 5 SUB.
  - 6 signed MULT: {hi,lo} = a*b, 64-bit. 7 unsigned MULTU: same, unsigned.
  - 8 SLL: b<<shamt. 9 SRL: b>>shamt. 10 SRA: b>>>shamt, arithmetic.
  - 12 SLT: signed a<b gives 1, else 0. 13 SLTU: unsigned compare.
  - Any other op gives lo = 0, hi = 0.
  - Add/sub wrap mod 2^32; no overflow trap.
- ALU operands: a = rs_data. b is selected by alu_src:
  - 0: rt_data.
  - 1: sign-extended imm16.
  - 2: zero-extended imm16.
- Decode, R-type (opcode 0, dest rd), by funct:
  - 0x00 sll, 0x02 srl, 0x03 sra: shamt = instr[10:6].
  - 0x20/0x21 add/addu, 0x22/0x23 sub/subu.
  - 0x24 and, 0x25 or, 0x26 xor, 0x27 nor.
  - 0x2A slt, 0x2B sltu.
  - 0x18 mult, 0x19 multu: write HI/LO at clock edge, no GPR write.
  - 0x10 mfhi: writes HI to rd. 0x12 mflo: writes LO to rd.
- Decode, I-type (dest rt):
  - 0x08/0x09 addi/addiu: sign-extended imm.
  - 0x0C andi, 0x0D ori, 0x0E xori: zero-extended imm.
  - 0x0A slti, 0x0B sltiu: sign-extended imm, compare signed/unsigned respectively.
  - 0x0F lui: b = zero-extended imm, op SLL, shamt = 16.
- Decode, GPIO (opcode 0x10):
  - rs field 0x00 (read): rt <= gpio_in.
  - rs field 0x04 (write): gpio_out <= rt_data at the clock edge; no GPR write.
- Unknown opcode/funct: no GPR, HI/LO or GPIO write (acts as NOP).
- Writeback source regsel: 0 ALU lo, 1 HI, 2 LO, 3 gpio_in.
  - Sampled into writedata_wb at the edge that ends EX, giving 1-cycle latency.
  - The register file commits on the following edge.
- Back-to-back dependent instructions must see correct values via bypass, with no stall.
- A mult followed immediately by mfhi/mflo returns the new product.
- Async reset mid-operation clears all state immediately; the pending writeback is discarded.

Test Plan:
- addi r1,r0,5 then addi r2,r1,-3 on consecutive cycles: the second instruction reads 5 via bypass; after writeback r1=5, r2=2.
- lui r3,0x1234; ori r3,r3,0x5678: r3=0x12345678. xori/andi with 0xFFFF: zero extension checked.
- r4=0xFFFFFFFE (-2), r5=3:
  - mult then mfhi/mflo: HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - multu: HI=0x00000002, LO=0xFFFFFFFA.
- Shift/compare with r5=0x80000000:
  - sra by 4: 0xF8000000. srl by 4: 0x08000000.
  - slt(-2,3)=1. sltu(0xFFFFFFFE,3)=0.
  - sub r6,r5,r5: alu_zero=1.
- GPIO: gpio_in=0xA5A5A5A5 with read into r7, then write r7 → gpio_out=0xA5A5A5A5 one edge after the write instruction. A write to r0 leaves r0=0.
- Assert rst while regwrite_wb=1: all outputs and registers return to 0; gpio_out=0.
